// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game controller.
// Board cell i maps to bit i, cells numbered 0..8 row-major.
package ttt_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_O = 3'd0,
      ST_CHK_O  = 3'd1,
      ST_X_MOVE = 3'd2,
      ST_CHK_X  = 3'd3,
      ST_DONE   = 3'd4
   } ttt_state_t;

   localparam logic [1:0] RES_PLAY = 2'd0;
   localparam logic [1:0] RES_XWIN = 2'd1;
   localparam logic [1:0] RES_OWIN = 2'd2;
   localparam logic [1:0] RES_DRAW = 2'd3;

   // Rows, columns, then the two diagonals.
   localparam logic [7:0][8:0] WIN_LINES = {
      9'h007, 9'h038, 9'h1C0,
      9'h049, 9'h092, 9'h124,
      9'h111, 9'h054
   };

   function automatic logic is_onehot9(input logic [8:0] v);
      return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
   endfunction

endpackage

// File: rtl/ttt_line_detect.sv
// Flags a board that fully covers at least one row, column or diagonal.
module ttt_line_detect
   import ttt_pkg::*;
(
   input  logic [8:0] board,
   output logic       line
);

   logic [7:0] hit;

   // Per-line coverage test.
   always_comb begin
      hit = 8'd0;
      for (int i = 0; i < 8; i++) begin
         hit[i] = ((board & WIN_LINES[i]) == WIN_LINES[i]);
      end
   end

   assign line = |hit;

endmodule

// File: rtl/tictactoe_game_ctrl.sv
// Game sequencer: owns the boards, accepts O moves, commits the generator's
// X move and reports win, draw, illegal offers and generator faults.
module tictactoe_game_ctrl
   import ttt_pkg::*;
#(
   parameter bit X_FIRST = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       new_game,
   input  logic       o_valid,
   input  logic [8:0] o_move,
   output logic       o_ready,
   output logic [8:0] gen_xin,
   output logic [8:0] gen_oin,
   input  logic [8:0] gen_next,
   output logic [8:0] x_board,
   output logic [8:0] o_board,
   output logic [1:0] result,
   output logic       game_over,
   output logic       illegal,
   output logic       fault,
   output logic [3:0] ply_count
);

   localparam ttt_state_t START_ST = X_FIRST ? ST_X_MOVE : ST_WAIT_O;

   ttt_state_t state_q, state_d;
   logic [8:0] x_q, x_d, o_q, o_d;
   logic [3:0] ply_q, ply_d;
   logic [1:0] result_q, result_d;
   logic       fault_q, fault_d;
   logic       illegal_q, illegal_d;

   logic [8:0] xm;
   logic       o_legal, xm_ok, x_line, o_line;

   ttt_line_detect u_x_line (.board(x_q), .line(x_line));
   ttt_line_detect u_o_line (.board(o_q), .line(o_line));

   // The generator answers with xin plus one new bit; isolate that bit.
   assign xm      = gen_next & ~x_q;
   assign o_legal = is_onehot9(o_move) && ((o_move & (x_q | o_q)) == 9'd0);
   assign xm_ok   = is_onehot9(xm) && ((xm & o_q) == 9'd0);

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= START_ST;
         x_q       <= 9'd0;
         o_q       <= 9'd0;
         ply_q     <= 4'd0;
         result_q  <= RES_PLAY;
         fault_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         o_q       <= o_d;
         ply_q     <= ply_d;
         result_q  <= result_d;
         fault_q   <= fault_d;
         illegal_q <= illegal_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      o_d       = o_q;
      ply_d     = ply_q;
      result_d  = result_q;
      fault_d   = fault_q;
      illegal_d = 1'b0;
      if (new_game) begin
         state_d  = START_ST;
         x_d      = 9'd0;
         o_d      = 9'd0;
         ply_d    = 4'd0;
         result_d = RES_PLAY;
         fault_d  = 1'b0;
      end else begin
         case (state_q)
            ST_WAIT_O: begin
               if (o_valid && o_legal) begin
                  o_d     = o_q | o_move;
                  ply_d   = ply_q + 4'd1;
                  state_d = ST_CHK_O;
               end else if (o_valid) begin
                  illegal_d = 1'b1;
               end else begin
                  state_d = ST_WAIT_O;
               end
            end
            ST_CHK_O: begin
               if (o_line) begin
                  result_d = RES_OWIN;
                  state_d  = ST_DONE;
               end else if (ply_q == 4'd9) begin
                  result_d = RES_DRAW;
                  state_d  = ST_DONE;
               end else begin
                  state_d = ST_X_MOVE;
               end
            end
            ST_X_MOVE: begin
               if (xm_ok) begin
                  x_d     = x_q | xm;
                  ply_d   = ply_q + 4'd1;
                  state_d = ST_CHK_X;
               end else begin
                  fault_d  = 1'b1;
                  result_d = RES_DRAW;
                  state_d  = ST_DONE;
               end
            end
            ST_CHK_X: begin
               if (x_line) begin
                  result_d = RES_XWIN;
                  state_d  = ST_DONE;
               end else if (ply_q == 4'd9) begin
                  result_d = RES_DRAW;
                  state_d  = ST_DONE;
               end else begin
                  state_d = ST_WAIT_O;
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = START_ST;
            end
         endcase
      end
   end

   // Outputs decoded from registered state only.
   always_comb begin
      o_ready   = (state_q == ST_WAIT_O);
      game_over = (state_q == ST_DONE);
      gen_xin   = x_q;
      gen_oin   = o_q;
      x_board   = x_q;
      o_board   = o_q;
      result    = result_q;
      fault     = fault_q;
      illegal   = illegal_q;
      ply_count = ply_q;
   end

endmodule

// File: tb/tb_tictactoe_game_ctrl.sv
// Randomized self-checking bench: one O-first and one X-first controller,
// each paired with a behavioural move generator and a game-level model.
module tb_tictactoe_game_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       ng0, ov0, ng1, ov1;
   logic [8:0] om0, om1;
   logic       rdy0, rdy1, go0v, go1v, ill0, ill1, flt0o, flt1o;
   logic [8:0] gx0, gox0, gn0, x0, o0, gx1, gox1, gn1, x1, o1;
   logic [1:0] res0, res1;
   logic [3:0] ply0, ply1;

   int         off0 = 0;
   logic       flt0 = 1'b0;
   int         n_cmp = 0;
   int         n_err = 0;

   logic [8:0] mx, mo;
   int         mply, mres;
   logic       mfault, mdone;

   tictactoe_game_ctrl #(.X_FIRST(1'b0)) dut0 (
      .clk(clk), .reset(reset), .new_game(ng0), .o_valid(ov0), .o_move(om0),
      .o_ready(rdy0), .gen_xin(gx0), .gen_oin(gox0), .gen_next(gn0),
      .x_board(x0), .o_board(o0), .result(res0), .game_over(go0v),
      .illegal(ill0), .fault(flt0o), .ply_count(ply0)
   );

   tictactoe_game_ctrl #(.X_FIRST(1'b1)) dut1 (
      .clk(clk), .reset(reset), .new_game(ng1), .o_valid(ov1), .o_move(om1),
      .o_ready(rdy1), .gen_xin(gx1), .gen_oin(gox1), .gen_next(gn1),
      .x_board(x1), .o_board(o1), .result(res1), .game_over(go1v),
      .illegal(ill1), .fault(flt1o), .ply_count(ply1)
   );

   // First empty cell scanning cyclically from off; -1 when the board is full.
   function automatic int pick_cell(input logic [8:0] x, input logic [8:0] o, input int off);
      for (int k = 0; k < 9; k++) begin
         int c;
         c = (off + k) % 9;
         if (!x[c] && !o[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [8:0] gen_model(input logic [8:0] x, input logic [8:0] o,
                                            input int off, input logic bad);
      int c;
      if (bad) return x | (o & (~o + 9'd1));
      c = pick_cell(x, o, off);
      if (c < 0) return x;
      return x | (9'd1 << c);
   endfunction

   function automatic bit has_line(input logic [8:0] b);
      for (int r = 0; r < 3; r++)
         if (b[3*r] && b[3*r+1] && b[3*r+2]) return 1'b1;
      for (int c = 0; c < 3; c++)
         if (b[c] && b[c+3] && b[c+6]) return 1'b1;
      return (b[0] && b[4] && b[8]) || (b[2] && b[4] && b[6]);
   endfunction

   function automatic logic [8:0] rand_cell(input logic [8:0] occ, input bit want_empty);
      int cnt, j;
      cnt = want_empty ? 9 - $countones(occ) : $countones(occ);
      j = $urandom_range(0, cnt - 1);
      for (int i = 0; i < 9; i++) begin
         if (occ[i] != want_empty) begin
            if (j == 0) return 9'd1 << i;
            j--;
         end
      end
      return 9'd0;
   endfunction

   always_comb gn0 = gen_model(gx0, gox0, off0, flt0);
   always_comb gn1 = gen_model(gx1, gox1, 0, 1'b0);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      mx = 9'd0; mo = 9'd0; mply = 0; mres = 0; mfault = 1'b0; mdone = 1'b0;
   endtask

   task automatic check_all0(input string tag);
      chk({tag, "_xb"}, x0, mx);
      chk({tag, "_ob"}, o0, mo);
      chk({tag, "_ply"}, ply0, mply);
      chk({tag, "_res"}, res0, mres);
      chk({tag, "_fault"}, flt0o, mfault);
      chk({tag, "_over"}, go0v, mdone);
   endtask

   task automatic new_game0();
      ng0 = 1'b1; tick(); ng0 = 1'b0;
      model_clear();
      check_all0("ng");
      chk("ng_rdy", rdy0, 1'b1);
   endtask

   // One O offer followed by the full turn it triggers.
   task automatic o_turn(input logic [8:0] mv);
      logic legal;
      chk("rdy_wait", rdy0, 1'b1);
      legal = ($countones(mv) == 1) && ((mv & (mx | mo)) == 9'd0);
      ov0 = 1'b1; om0 = mv; tick(); ov0 = 1'b0; om0 = 9'd0;
      if (!legal) begin
         chk("illegal_pulse", ill0, 1'b1);
         check_all0("illegal");
         chk("illegal_rdy", rdy0, 1'b1);
         return;
      end
      chk("legal_nopulse", ill0, 1'b0);
      mo |= mv; mply++;
      chk("rdy_lo1", rdy0, 1'b0);
      check_all0("o_commit");
      if (has_line(mo) || mply == 9) begin
         mres = has_line(mo) ? 2 : 3; mdone = 1'b1;
         tick(); check_all0("o_end"); chk("rdy_oend", rdy0, 1'b0);
         return;
      end
      tick(); chk("rdy_lo2", rdy0, 1'b0);
      if (flt0) begin
         mfault = 1'b1; mres = 3; mdone = 1'b1;
         tick(); check_all0("fault"); chk("rdy_fault", rdy0, 1'b0);
         return;
      end
      mx |= 9'd1 << pick_cell(mx, mo, off0); mply++;
      tick(); chk("rdy_lo3", rdy0, 1'b0); check_all0("x_commit");
      if (has_line(mx) || mply == 9) begin
         mres = has_line(mx) ? 1 : 3; mdone = 1'b1;
         tick(); check_all0("x_end"); chk("rdy_xend", rdy0, 1'b0);
         return;
      end
      tick(); chk("rdy_back", rdy0, 1'b1); check_all0("turn_end");
   endtask

   task automatic check_done_holds();
      ov0 = 1'b1; om0 = rand_cell(mx | mo, 1'b0); tick(); ov0 = 1'b0;
      tick();
      check_all0("done_hold");
      chk("done_noill", ill0, 1'b0);
      chk("done_rdy", rdy0, 1'b0);
   endtask

   task automatic finish_random(input int budget);
      int n = 0;
      while (!mdone && n < budget) begin
         int r;
         logic [8:0] mv;
         r = $urandom_range(0, 9);
         if (r == 0) mv = 9'($urandom);
         else if (r == 1 && (mx | mo) != 9'd0) mv = rand_cell(mx | mo, 1'b0);
         else mv = rand_cell(mx | mo, 1'b1);
         o_turn(mv);
         n++;
      end
      chk("game_end", go0v, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      reset = 1'b1; ng0 = 1'b1; ng1 = 1'b1; ov0 = 1'b0; ov1 = 1'b0;
      om0 = 9'd0; om1 = 9'd0;
      model_clear();
      tick(); ng0 = 1'b0; ng1 = 1'b0; tick();
      check_all0("reset");
      chk("reset_ill", ill0, 1'b0);
      chk("reset_rdy0", rdy0, 1'b1);
      chk("reset_rdy1", rdy1, 1'b0);
      chk("reset_x1", x1, 9'd0);

      // X-first controller: first ply, then new_game in CHK_O and against an offer.
      reset = 1'b0; tick();
      chk("x1_first", x1, 9'd1 << pick_cell(9'd0, 9'd0, 0));
      chk("x1_ply1", ply1, 4'd1);
      chk("x1_rdy_chkx", rdy1, 1'b0);
      tick(); chk("x1_rdy", rdy1, 1'b1);
      ov1 = 1'b1; om1 = 9'h010; tick(); ov1 = 1'b0;
      chk("x1_o", o1, 9'h010); chk("x1_ply2", ply1, 4'd2); chk("x1_rdy_chko", rdy1, 1'b0);
      ng1 = 1'b1; tick(); ng1 = 1'b0;
      chk("ng1_x", x1, 9'd0); chk("ng1_o", o1, 9'd0); chk("ng1_ply", ply1, 4'd0);
      chk("ng1_rdy", rdy1, 1'b0); chk("ng1_over", go1v, 1'b0);
      tick();
      chk("ng1_xcommit", x1, 9'd1 << pick_cell(9'd0, 9'd0, 0)); chk("ng1_ply1", ply1, 4'd1);
      tick(); chk("ng1_rdy2", rdy1, 1'b1);
      ov1 = 1'b1; om1 = 9'h100; ng1 = 1'b1; tick(); ov1 = 1'b0; ng1 = 1'b0;
      chk("ngprio_o", o1, 9'd0); chk("ngprio_ply", ply1, 4'd0);

      // Scripted opening with first-empty generator, then illegal offers.
      off0 = 0; flt0 = 1'b0; new_game0();
      o_turn(9'h010); o_turn(9'h100); o_turn(9'h004);
      o_turn(9'h003); o_turn(9'h010); o_turn(9'h000);
      finish_random(40);
      check_done_holds();

      // O wins on the top row.
      off0 = 3; new_game0();
      o_turn(9'h001); o_turn(9'h002); o_turn(9'h004);
      chk("owin_res", res0, 2'd2);
      check_done_holds();

      // Full 9-ply draw.
      off0 = 5; new_game0();
      o_turn(9'h010); o_turn(9'h002); o_turn(9'h008); o_turn(9'h100); o_turn(9'h004);
      chk("draw_ply", ply0, 4'd9); chk("draw_res", res0, 2'd3); chk("draw_fault", flt0o, 1'b0);

      // Generator fault: answers with an O-occupied cell.
      flt0 = 1'b1; new_game0();
      o_turn(rand_cell(9'd0, 1'b1));
      chk("fault_flag", flt0o, 1'b1);
      check_done_holds();
      flt0 = 1'b0;

      // Randomized games, a few with a faulty generator.
      for (int g = 0; g < 30; g++) begin
         flt0 = ($urandom_range(0, 5) == 0);
         off0 = $urandom_range(0, 8);
         new_game0();
         finish_random(40);
      end
      flt0 = 1'b0;

      // Reset mid-game outranks a simultaneous offer.
      off0 = 0; new_game0();
      o_turn(9'h010);
      reset = 1'b1; ov0 = 1'b1; om0 = 9'h100; tick(); reset = 1'b0; ov0 = 1'b0;
      model_clear();
      check_all0("midreset");
      chk("midreset_rdy", rdy0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
